// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// MEM-stage load/store unit. Sits directly behind the EX/MEM pipeline register
// and turns the instruction held there into at most one data-bus transaction.
//
//   * Store path: replicates the store data across byte lanes and generates
//     byte enables from the access size and address offset.
//   * Load path: selects the addressed byte/half from the returned word and
//     sign- or zero-extends it into mem_dm_dout.
//   * mem_stall holds the pipeline frozen from the first cycle an access is
//     seen until it completes, errors out or times out.
//
// Parameters
//   TIMEOUT    cycles allowed in REQ+WAIT_R before the access is aborted
//   RF_SEL_DM  mem_rf_din_sel code that marks a load
//
// Ports
//   clk, rst                  clock (posedge) / asynchronous active-high reset
//   mem_alu_dout              byte address from EX/MEM
//   mem_mux_out_rf_dout_rs2   store data from EX/MEM
//   mem_dm_func               funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_dm_we                 store request
//   mem_rf_din_sel            write-back select; == RF_SEL_DM means load
//   mem_pipe_adv              EX/MEM register advances at this edge
//   dbus_req, dbus_we         bus request / write strobe (registered)
//   dbus_addr                 word-aligned address (registered)
//   dbus_be, dbus_wdata       byte enables / lane-replicated data (registered)
//   dbus_ready                request accepted when dbus_req & dbus_ready
//   dbus_rvalid, dbus_rdata   read response
//   mem_stall                 pipeline freeze (combinational)
//   mem_dm_dout               extended load data to MEM/WB (registered)
//   mem_misalign              misaligned access in stage (combinational)
//   mem_bus_err               current access timed out (registered)
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int         TIMEOUT   = 16,
    parameter logic [1:0] RF_SEL_DM = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_dout,
    input  logic [31:0] mem_mux_out_rf_dout_rs2,
    input  logic [2:0]  mem_dm_func,
    input  logic        mem_dm_we,
    input  logic [1:0]  mem_rf_din_sel,
    input  logic        mem_pipe_adv,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ready,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_dm_dout,
    output logic        mem_misalign,
    output logic        mem_bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Load context captured at issue so the response is decoded against the
    // access that was actually sent, independent of what EX/MEM shows later.
    logic [2:0]       ld_func;
    logic [1:0]       ld_off;

    logic             is_load;
    logic             access;
    logic             size_h;
    logic             size_w;
    logic             mis;

    // ------------------------------------------------------------------
    // Lane helpers
    // ------------------------------------------------------------------

    // Byte enables. Only funct3[1:0] is looked at: bit 2 (unsigned) has no
    // meaning for stores, and the reserved codes 011/11x fall into the W arm.
    function automatic logic [3:0] lane_be(input logic [1:0] sz,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the memory only needs to
    // honour the byte enables.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  sz,
                                               input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half from the returned word and extend it.
    // B/H sign-extend, BU/HU zero-extend, W and reserved codes pass through.
    function automatic logic [31:0] load_extend(input logic [2:0]  func,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        logic        [31:0] r;
        b  = rdata[{off, 3'b000} +: 8];
        h  = off[1] ? rdata[31:16] : rdata[15:0];
        sb = b;
        sh = h;
        sx = 32'sd0;
        case (func)
            3'b000: begin
                sx = sb;
                r  = sx;
            end
            3'b100:  r = {24'h000000, b};
            3'b001: begin
                sx = sh;
                r  = sx;
            end
            3'b101:  r = {16'h0000, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    always_comb begin
        is_load = (mem_rf_din_sel == RF_SEL_DM);
        access  = mem_dm_we | is_load;
        size_h  = (mem_dm_func[1:0] == 2'b01);
        size_w  = mem_dm_func[1];
        mis     = (size_h & mem_alu_dout[0]) |
                  (size_w & (mem_alu_dout[1:0] != 2'b00));
    end

    // A misaligned access never touches the bus and never stalls; the trap
    // logic downstream sees mem_misalign instead. DONE releases the stall so
    // the pipeline can advance past the completed access.
    assign mem_misalign = access & mis;
    assign mem_stall    = access & ~mis & (state != DONE);

    // ------------------------------------------------------------------
    // Transaction FSM with registered bus/result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ld_func     <= 3'b000;
            ld_off      <= 2'b00;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= 32'h0;
            dbus_be     <= 4'h0;
            dbus_wdata  <= 32'h0;
            mem_dm_dout <= 32'h0;
            mem_bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !mis) begin
                        state      <= REQ;
                        cnt        <= '0;
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_dm_we;
                        dbus_addr  <= {mem_alu_dout[31:2], 2'b00};
                        dbus_be    <= lane_be(mem_dm_func[1:0], mem_alu_dout[1:0]);
                        dbus_wdata <= lane_wdata(mem_dm_func[1:0],
                                                 mem_mux_out_rf_dout_rs2);
                        ld_func    <= mem_dm_func;
                        ld_off     <= mem_alu_dout[1:0];
                    end else if (access && mis && !mem_dm_we) begin
                        // Misaligned load writes back zero rather than stale data.
                        mem_dm_dout <= 32'h0;
                    end
                end

                REQ: begin
                    // Acceptance is checked before the timeout so a ready
                    // arriving on the last allowed cycle still completes.
                    if (dbus_ready) begin
                        dbus_req <= 1'b0;
                        dbus_we  <= 1'b0;
                        cnt      <= cnt + 1'b1;
                        state    <= dbus_we ? DONE : WAIT_R;
                    end else if (cnt == CNT_LAST) begin
                        dbus_req    <= 1'b0;
                        dbus_we     <= 1'b0;
                        mem_bus_err <= 1'b1;
                        mem_dm_dout <= 32'h0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_R: begin
                    // The count carries over from REQ: the budget covers the
                    // whole access, not each phase separately.
                    if (dbus_rvalid) begin
                        mem_dm_dout <= load_extend(ld_func, ld_off, dbus_rdata);
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_bus_err <= 1'b1;
                        mem_dm_dout <= 32'h0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Holding here while the pipeline is frozen by someone
                    // else keeps the same store from being issued twice.
                    if (mem_pipe_adv) begin
                        mem_bus_err <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Drives single MEM-stage accesses into mem_stage_lsu with a simple bus
// responder. Expected bus transactions and load results are queued when an
// access is driven and compared when the DUT accepts a request or finishes.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    localparam logic [1:0] SEL_DM  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    logic        clk;
    logic        rst;
    logic [31:0] mem_alu_dout;
    logic [31:0] mem_mux_out_rf_dout_rs2;
    logic [2:0]  mem_dm_func;
    logic        mem_dm_we;
    logic [1:0]  mem_rf_din_sel;
    logic        mem_pipe_adv;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ready;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [31:0] mem_dm_dout;
    logic        mem_misalign;
    logic        mem_bus_err;

    mem_stage_lsu #(
        .TIMEOUT   (16),
        .RF_SEL_DM (SEL_DM)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_alu_dout            (mem_alu_dout),
        .mem_mux_out_rf_dout_rs2 (mem_mux_out_rf_dout_rs2),
        .mem_dm_func             (mem_dm_func),
        .mem_dm_we               (mem_dm_we),
        .mem_rf_din_sel          (mem_rf_din_sel),
        .mem_pipe_adv            (mem_pipe_adv),
        .dbus_req                (dbus_req),
        .dbus_we                 (dbus_we),
        .dbus_addr               (dbus_addr),
        .dbus_be                 (dbus_be),
        .dbus_wdata              (dbus_wdata),
        .dbus_ready              (dbus_ready),
        .dbus_rvalid             (dbus_rvalid),
        .dbus_rdata              (dbus_rdata),
        .mem_stall               (mem_stall),
        .mem_dm_dout             (mem_dm_dout),
        .mem_misalign            (mem_misalign),
        .mem_bus_err             (mem_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    bus_t        req_q[$];
    logic [31:0] dout_q[$];
    logic [31:0] cur_dout;

    int total = 0;
    int bad   = 0;
    int req_cycles = 0;

    logic        rv_en;
    logic        rv_force;
    logic [31:0] rdata_tb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the lane / extension rules.
    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [1:0] a);
        if (f[1:0] == 2'b00) begin
            case (a)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end else if (f[1:0] == 2'b01) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        if (f[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f[1:0] == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f, input logic [1:0] a,
                                         input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * a);
        case (f)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f, input logic [1:0] a);
        return ((f[1:0] == 2'b01) && a[0]) || (f[1] && (a != 2'b00));
    endfunction

    // Bus responder / monitor: checks each accepted request against the
    // queue and returns read data the cycle after a load is accepted.
    always begin
        logic acc;
        logic ld;
        bus_t e;
        @(negedge clk);
        if (dbus_req) req_cycles++;
        acc = dbus_req && dbus_ready;
        ld  = acc && !dbus_we;
        if (acc) begin
            if (req_q.size() == 0) begin
                chk("spurious_req", 32'd1, 32'd0);
            end else begin
                e = req_q.pop_front();
                chk("bus_addr", dbus_addr, e.addr);
                chk("bus_we", 32'(dbus_we), 32'(e.we));
                if (e.we) begin
                    chk("bus_be", 32'(dbus_be), 32'(e.be));
                    chk("bus_wdata", dbus_wdata, e.wdata);
                end
            end
        end
        @(posedge clk);
        #1;
        dbus_rvalid = (ld && rv_en) || rv_force;
        dbus_rdata  = rdata_tb;
    end

    task automatic idle_inputs();
        mem_alu_dout            = 32'h0;
        mem_mux_out_rf_dout_rs2 = 32'h0;
        mem_dm_func             = 3'b000;
        mem_dm_we               = 1'b0;
        mem_rf_din_sel          = SEL_ALU;
    endtask

    // One access: lat = REQ cycles with ready low, hold = extra DONE cycles
    // with mem_pipe_adv low.
    task automatic run_op(input string nm, input logic we, input logic [2:0] f,
                          input logic [31:0] addr, input logic [31:0] d,
                          input logic [31:0] rd, input int lat, input int hold,
                          input int exp_stall, input logic exp_err, input int exp_reqc);
        logic mis;
        int   n;
        int   j;
        int   rc0;
        bus_t e;
        mis = m_mis(f, addr[1:0]);
        @(posedge clk);
        #1;
        rc0                     = req_cycles;
        mem_alu_dout            = addr;
        mem_mux_out_rf_dout_rs2 = d;
        mem_dm_func             = f;
        mem_dm_we               = we;
        mem_rf_din_sel          = we ? SEL_ALU : SEL_DM;
        mem_pipe_adv            = (hold == 0);
        dbus_ready              = (lat == 0);
        rdata_tb                = rd;
        rv_en                   = 1'b1;
        if (!mis && !exp_err) begin
            e.addr  = {addr[31:2], 2'b00};
            e.we    = we;
            e.be    = m_be(f, addr[1:0]);
            e.wdata = m_wdata(f, d);
            req_q.push_back(e);
        end
        if (!we && (mis || exp_err)) dout_q.push_back(32'h0);
        else if (!we)                dout_q.push_back(m_ld(f, addr[1:0], rd));
        else if (exp_err)            dout_q.push_back(32'h0);

        if (mis) begin
            @(negedge clk);
            chk({nm, "_misalign"}, 32'(mem_misalign), 32'd1);
            chk({nm, "_stall"}, 32'(mem_stall), 32'd0);
            chk({nm, "_noreq"}, 32'(dbus_req), 32'd0);
            @(posedge clk);
            #1;
            idle_inputs();
            @(negedge clk);
            if (dout_q.size() > 0) cur_dout = dout_q.pop_front();
            chk({nm, "_dout"}, mem_dm_dout, cur_dout);
            chk({nm, "_noreq2"}, 32'(req_cycles - rc0), 32'd0);
        end else begin
            n = 0;
            j = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (!mem_stall) break;
                n++;
                @(posedge clk);
                #1;
                j++;
                dbus_ready = ((j - 1) >= lat);
            end
            chk({nm, "_stallcyc"}, 32'(n), 32'(exp_stall));
            chk({nm, "_err"}, 32'(mem_bus_err), 32'(exp_err));
            chk({nm, "_reqcyc"}, 32'(req_cycles - rc0), 32'(exp_reqc));
            chk({nm, "_reqlow"}, 32'(dbus_req), 32'd0);
            if (dout_q.size() > 0) cur_dout = dout_q.pop_front();
            chk({nm, "_dout"}, mem_dm_dout, cur_dout);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk({nm, "_hold_stall"}, 32'(mem_stall), 32'd0);
                chk({nm, "_hold_req"}, 32'(dbus_req), 32'd0);
            end
            if (hold > 0) begin
                chk({nm, "_hold_reqcyc"}, 32'(req_cycles - rc0), 32'(exp_reqc));
                @(posedge clk);
                #1;
                mem_pipe_adv = 1'b1;
            end
            @(posedge clk);
            #1;
            idle_inputs();
            dbus_ready = 1'b1;
            @(negedge clk);
            chk({nm, "_errclr"}, 32'(mem_bus_err), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        mem_pipe_adv = 1'b1;
        dbus_ready   = 1'b1;
        dbus_rvalid  = 1'b0;
        dbus_rdata   = 32'h0;
        rv_en        = 1'b1;
        rv_force     = 1'b0;
        rdata_tb     = 32'h0;
        cur_dout     = 32'h0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_addr", dbus_addr, 32'h0);
        chk("rst_be", 32'(dbus_be), 32'd0);
        chk("rst_wdata", dbus_wdata, 32'h0);
        chk("rst_dout", mem_dm_dout, 32'h0);
        chk("rst_err", 32'(mem_bus_err), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);

        //      name     we    f       addr          d             rd         lat hold stall err reqc
        run_op("sw",     1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344, 32'h0,        0, 0, 2, 1'b0, 1);
        run_op("lb",     1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 0, 0, 3, 1'b0, 1);
        run_op("lbu",    1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 0, 0, 3, 1'b0, 1);
        run_op("sh",     1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        0, 0, 2, 1'b0, 1);
        run_op("lh_mis", 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 0, 1'b0, 0);
        run_op("sb",     1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 32'h0,        0, 0, 2, 1'b0, 1);
        run_op("lh",     1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h8001_1234, 0, 0, 3, 1'b0, 1);
        run_op("lhu",    1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h8001_1234, 0, 0, 3, 1'b0, 1);
        run_op("lw_lat", 1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 3, 0, 6, 1'b0, 4);
        run_op("sh_u",   1'b1, 3'b101, 32'h0000_0100, 32'h0000_1234, 32'h0,        0, 0, 2, 1'b0, 1);
        run_op("ld_rsv", 1'b0, 3'b111, 32'h0000_0208, 32'h0,        32'h0BAD_F00D, 0, 0, 3, 1'b0, 1);
        run_op("sw_mis", 1'b1, 3'b010, 32'h0000_0102, 32'h5555_5555, 32'h0,        0, 0, 0, 1'b0, 0);
        run_op("lw_to",  1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h7777_7777, 20, 0, 17, 1'b1, 16);
        run_op("sw_edge",1'b1, 3'b010, 32'h0000_0104, 32'hA5A5_5A5A, 32'h0,        15, 0, 17, 1'b0, 16);
        run_op("sw_hold",1'b1, 3'b010, 32'h0000_0108, 32'h0102_0304, 32'h0,        0, 3, 2, 1'b0, 1);
        run_op("lw",     1'b0, 3'b010, 32'h0000_020C, 32'h0,        32'hCAFE_F00D, 0, 0, 3, 1'b0, 1);

        // Reset while a load waits for its response.
        begin
            bus_t e;
            @(posedge clk);
            #1;
            mem_alu_dout   = 32'h0000_0210;
            mem_dm_func    = 3'b010;
            mem_dm_we      = 1'b0;
            mem_rf_din_sel = SEL_DM;
            dbus_ready     = 1'b1;
            rv_en          = 1'b0;
            rdata_tb       = 32'h1357_9BDF;
            e.addr  = 32'h0000_0210;
            e.we    = 1'b0;
            e.be    = 4'hF;
            e.wdata = 32'h0;
            req_q.push_back(e);
            repeat (4) @(negedge clk);
            chk("waitr_stall", 32'(mem_stall), 32'd1);
            #2;
            rst = 1'b1;
            idle_inputs();
            #1;
            chk("arst_req", 32'(dbus_req), 32'd0);
            chk("arst_dout", mem_dm_dout, 32'h0);
            chk("arst_err", 32'(mem_bus_err), 32'd0);
            chk("arst_addr", dbus_addr, 32'h0);
            chk("arst_stall", 32'(mem_stall), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            cur_dout = 32'h0;
            @(posedge clk);
            #1;
            rdata_tb = 32'h1234_5678;
            rv_force = 1'b1;
            @(posedge clk);
            #1;
            rv_force = 1'b0;
            rv_en    = 1'b1;
            @(negedge clk);
            chk("late_rvalid_dout", mem_dm_dout, cur_dout);
            chk("late_rvalid_req", 32'(dbus_req), 32'd0);
        end

        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
